// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit path: state encoding, line levels, parity helper.
package serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic LINE_IDLE = 1'b1;

    localparam int unsigned MAX_DATA_W = 16;

    // Unused upper bits are zero-filled by the caller, so they do not affect the XOR.
    function automatic logic parity_calc(input logic [MAX_DATA_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each serial bit.
module baud_tick_gen #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt + CNT_W'(1);
        if (clear || (cnt == LAST)) begin
            cnt_d = '0;
        end
    end

    // tick is registered but always equals (cnt == LAST); with one clock per bit it stays high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            tick <= (LAST == '0);
        end else begin
            cnt  <= cnt_d;
            tick <= (cnt_d == LAST);
        end
    end

endmodule

// File: rtl/serial_tx_piso.sv
// Parallel-in serial-out frame transmitter: start bit, data LSB first, optional parity, stop bit.
module serial_tx_piso
    import serial_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY_EN    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              ser_out,
    output logic              busy,
    output logic              done
);

    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    state_t             state;
    state_t             state_d;
    logic [DATA_W-1:0]  shift;
    logic [DATA_W-1:0]  shift_d;
    logic [BIT_W-1:0]   bit_cnt;
    logic [BIT_W-1:0]   bit_cnt_d;
    logic               parity_bit;
    logic               parity_d;
    logic               ser_d;
    logic               busy_d;
    logic               done_d;
    logic               ready_d;
    logic               clear_c;
    logic               tick;

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .clear (clear_c),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            shift      <= '0;
            bit_cnt    <= '0;
            parity_bit <= 1'b0;
            ser_out    <= LINE_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            state      <= state_d;
            shift      <= shift_d;
            bit_cnt    <= bit_cnt_d;
            parity_bit <= parity_d;
            ser_out    <= ser_d;
            busy       <= busy_d;
            done       <= done_d;
            load_ready <= ready_d;
        end
    end

    // Outputs are computed one cycle ahead so the registered line changes together with state.
    always_comb begin
        state_d   = state;
        shift_d   = shift;
        bit_cnt_d = bit_cnt;
        parity_d  = parity_bit;
        ser_d     = ser_out;
        busy_d    = busy;
        done_d    = 1'b0;
        clear_c   = 1'b0;

        case (state)
            ST_IDLE: begin
                ser_d = LINE_IDLE;
                if (load_valid && load_ready) begin
                    state_d  = ST_START;
                    shift_d  = load_data;
                    parity_d = parity_calc(MAX_DATA_W'(load_data), 1'(PARITY_ODD));
                    clear_c  = 1'b1;
                    ser_d    = START_BIT;
                    busy_d   = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                    ser_d     = shift[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = shift >> 1;
                    if (bit_cnt == LAST_BIT) begin
                        if (PARITY_EN != 0) begin
                            state_d = ST_PARITY;
                            ser_d   = parity_bit;
                        end else begin
                            state_d = ST_STOP;
                            ser_d   = STOP_BIT;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt + BIT_W'(1);
                        ser_d     = shift_d[0];
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                    ser_d   = STOP_BIT;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    ser_d   = LINE_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ser_d   = LINE_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

endmodule

// File: tb/tb_serial_tx_piso.sv
// Directed bench for serial_tx_piso: three instances covering even/odd parity and one-clock bits.
module tb_serial_tx_piso;

    logic       clk;
    logic       reset;
    logic       lv   [3];
    logic [7:0] ld   [3];
    logic       rdy  [3];
    logic       ser  [3];
    logic       bsy  [3];
    logic       dn   [3];

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          s;
        logic [7:0]  d;
        logic [10:0] exp;
        int          nbits;
        int          cpb;
    } vec_t;

    serial_tx_piso u_even (
        .clk(clk), .reset(reset), .load_valid(lv[0]), .load_data(ld[0]),
        .load_ready(rdy[0]), .ser_out(ser[0]), .busy(bsy[0]), .done(dn[0])
    );

    serial_tx_piso #(.PARITY_ODD(1)) u_odd (
        .clk(clk), .reset(reset), .load_valid(lv[1]), .load_data(ld[1]),
        .load_ready(rdy[1]), .ser_out(ser[1]), .busy(bsy[1]), .done(dn[1])
    );

    serial_tx_piso #(.CLKS_PER_BIT(1), .PARITY_EN(0)) u_fast (
        .clk(clk), .reset(reset), .load_valid(lv[2]), .load_data(ld[2]),
        .load_ready(rdy[2]), .ser_out(ser[2]), .busy(bsy[2]), .done(dn[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input int s, input string nm);
        chk($sformatf("%s ser[%0d]", nm, s), ser[s], 1'b1);
        chk($sformatf("%s busy[%0d]", nm, s), bsy[s], 1'b0);
        chk($sformatf("%s done[%0d]", nm, s), dn[s], 1'b0);
        chk($sformatf("%s ready[%0d]", nm, s), rdy[s], 1'b1);
    endtask

    // Accept one word; returns at the negedge of the first START cycle with load_data scrambled.
    task automatic start_frame(input int s, input logic [7:0] d);
        @(negedge clk);
        chk($sformatf("ready before load %0d", s), rdy[s], 1'b1);
        lv[s] = 1'b1;
        ld[s] = d;
        @(negedge clk);
        lv[s] = 1'b0;
        ld[s] = ~d;
    endtask

    // Checks every cycle of a frame from the first START cycle; ends on the done cycle.
    task automatic check_frame(input int s, input logic [10:0] exp, input int nbits,
                               input int cpb, input logic inject);
        for (int i = 0; i < nbits; i++) begin
            for (int c = 0; c < cpb; c++) begin
                if (inject && i == 4 && c == 0) begin
                    lv[s] = 1'b1;
                    ld[s] = 8'h3C;
                end
                chk($sformatf("ser[%0d] bit%0d cyc%0d", s, i, c), ser[s], exp[i]);
                chk($sformatf("busy[%0d] bit%0d cyc%0d", s, i, c), bsy[s], 1'b1);
                chk($sformatf("ready[%0d] bit%0d cyc%0d", s, i, c), rdy[s], 1'b0);
                chk($sformatf("done[%0d] bit%0d cyc%0d", s, i, c), dn[s], 1'b0);
                @(negedge clk);
            end
        end
        chk($sformatf("done pulse[%0d]", s), dn[s], 1'b1);
        chk($sformatf("busy end[%0d]", s), bsy[s], 1'b0);
        chk($sformatf("ser end[%0d]", s), ser[s], 1'b1);
        chk($sformatf("ready end[%0d]", s), rdy[s], 1'b1);
    endtask

    vec_t vecs [8];

    initial begin
        // {stop, parity, data (LSB sent first), start}; 10-bit frames leave bit 10 unused.
        vecs[0] = '{0, 8'hA5, {1'b1, 1'b0, 8'hA5, 1'b0}, 11, 4};
        vecs[1] = '{0, 8'hFF, {1'b1, 1'b0, 8'hFF, 1'b0}, 11, 4};
        vecs[2] = '{1, 8'hFF, {1'b1, 1'b1, 8'hFF, 1'b0}, 11, 4};
        vecs[3] = '{0, 8'h01, {1'b1, 1'b1, 8'h01, 1'b0}, 11, 4};
        vecs[4] = '{1, 8'h01, {1'b1, 1'b0, 8'h01, 1'b0}, 11, 4};
        vecs[5] = '{0, 8'h00, {1'b1, 1'b0, 8'h00, 1'b0}, 11, 4};
        vecs[6] = '{1, 8'h96, {1'b1, 1'b1, 8'h96, 1'b0}, 11, 4};
        vecs[7] = '{2, 8'h96, {1'b0, 1'b1, 8'h96, 1'b0}, 10, 1};

        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lv[i] = 1'b0;
            ld[i] = 8'h00;
        end
        #1;
        for (int i = 0; i < 3; i++) chk_idle(i, "in reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Quiet line after reset.
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            chk_idle(0, "quiet");
        end

        for (int v = 0; v < 8; v++) begin
            start_frame(vecs[v].s, vecs[v].d);
            check_frame(vecs[v].s, vecs[v].exp, vecs[v].nbits, vecs[v].cpb, 1'b0);
            @(negedge clk);
            chk($sformatf("done single vec%0d", v), dn[vecs[v].s], 1'b0);
        end

        // Load attempt mid-frame is ignored; held valid starts the next frame right after done.
        start_frame(0, 8'h81);
        check_frame(0, {1'b1, 1'b0, 8'h81, 1'b0}, 11, 4, 1'b1);
        @(negedge clk);
        lv[0] = 1'b0;
        check_frame(0, {1'b1, 1'b0, 8'h3C, 1'b0}, 11, 4, 1'b0);
        @(negedge clk);
        chk("done after 3C", dn[0], 1'b0);

        // Reset during data bit 3 aborts immediately.
        start_frame(0, 8'h55);
        repeat (17) @(negedge clk);
        chk("ser before abort", ser[0], 1'b0);
        chk("busy before abort", bsy[0], 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("ser async reset", ser[0], 1'b1);
        chk("busy async reset", bsy[0], 1'b0);
        chk("ready async reset", rdy[0], 1'b1);
        lv[0] = 1'b1;
        ld[0] = 8'hC3;
        @(negedge clk);
        chk_idle(0, "held reset");
        @(negedge clk);
        chk_idle(0, "held reset");
        lv[0] = 1'b0;
        reset = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            chk_idle(0, "after abort");
        end
        start_frame(0, 8'h0F);
        check_frame(0, {1'b1, 1'b0, 8'h0F, 1'b0}, 11, 4, 1'b0);
        @(negedge clk);
        chk("done after 0F", dn[0], 1'b0);

        // Back-to-back one-clock frames with a single idle-high cycle between them.
        @(negedge clk);
        lv[2] = 1'b1;
        ld[2] = 8'h01;
        @(negedge clk);
        ld[2] = 8'h80;
        check_frame(2, {1'b0, 1'b1, 8'h01, 1'b0}, 10, 1, 1'b0);
        @(negedge clk);
        lv[2] = 1'b0;
        check_frame(2, {1'b0, 1'b1, 8'h80, 1'b0}, 10, 1, 1'b0);
        @(negedge clk);
        chk_idle(2, "fast after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
